cdc_level_filter: RTL and testbench

CDC_LEVEL_FILTER -- requirements
Module: cdc_level_filter

---
 rtl/cdc_level_filter.sv | 179 +++++++++++++++++
 tb/tb_cdc_level_filter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_level_filter.sv
// Debounce filter for a level already synchronized into clk_2: accepts a level change only after
// STABLE_CYCLES consecutive differing samples, then reports filtered edges, one pending event and a saturating edge count.
module cdc_level_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    input  logic                 i_data,
    input  logic                 i_evt_ready,
    input  logic                 i_cnt_clr,
    output logic                 o_data,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic                 o_evt_valid,
    output logic                 o_evt_type,
    output logic                 o_evt_ovf,
    output logic [CNT_WIDTH-1:0] o_edge_cnt
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    localparam logic [7:0]           STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic                 SINGLE    = (STABLE_CYCLES == 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [7:0]           stab_cnt_q, stab_cnt_d;
    logic                 data_q, data_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 evt_valid_q, evt_valid_d;
    logic                 evt_type_q, evt_type_d;
    logic                 evt_ovf_q, evt_ovf_d;
    logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;

    logic                 strobe_s;
    logic                 accept_s;
    logic                 drop_s;
    logic [CNT_WIDTH-1:0] cnt_base_s;

    // Filter FSM: next state, stability counter and edge strobes.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        case (state_q)
            S_LOW: begin
                if (i_data && SINGLE) begin
                    state_d    = S_HIGH;
                    stab_cnt_d = 8'd0;
                    rise_d     = 1'b1;
                end else if (i_data) begin
                    state_d    = S_CHK_HIGH;
                    stab_cnt_d = 8'd1;
                end else begin
                    state_d    = S_LOW;
                    stab_cnt_d = 8'd0;
                end
            end
            S_CHK_HIGH: begin
                if (!i_data) begin
                    state_d    = S_LOW;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = S_HIGH;
                    stab_cnt_d = 8'd0;
                    rise_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (!i_data && SINGLE) begin
                    state_d    = S_LOW;
                    stab_cnt_d = 8'd0;
                    fall_d     = 1'b1;
                end else if (!i_data) begin
                    state_d    = S_CHK_LOW;
                    stab_cnt_d = 8'd1;
                end else begin
                    state_d    = S_HIGH;
                    stab_cnt_d = 8'd0;
                end
            end
            S_CHK_LOW: begin
                if (i_data) begin
                    state_d    = S_HIGH;
                    stab_cnt_d = 8'd0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = S_LOW;
                    stab_cnt_d = 8'd0;
                    fall_d     = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_LOW;
                stab_cnt_d = 8'd0;
            end
        endcase
        data_d = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
    end

    // Single-entry event slot, overflow flag and saturating edge counter.
    always_comb begin
        strobe_s = rise_d | fall_d;
        accept_s = strobe_s && (!evt_valid_q || i_evt_ready);
        drop_s   = strobe_s && !accept_s;

        if (accept_s) begin
            evt_valid_d = 1'b1;
            evt_type_d  = rise_d;
        end else if (evt_valid_q && i_evt_ready) begin
            evt_valid_d = 1'b0;
            evt_type_d  = evt_type_q;
        end else begin
            evt_valid_d = evt_valid_q;
            evt_type_d  = evt_type_q;
        end

        // A drop in the same cycle as a clear must still be visible.
        if (drop_s) begin
            evt_ovf_d = 1'b1;
        end else if (i_cnt_clr) begin
            evt_ovf_d = 1'b0;
        end else begin
            evt_ovf_d = evt_ovf_q;
        end

        cnt_base_s = i_cnt_clr ? CNT_ZERO : edge_cnt_q;
        if (strobe_s && (cnt_base_s != CNT_MAX)) begin
            edge_cnt_d = cnt_base_s + CNT_ONE;
        end else begin
            edge_cnt_d = cnt_base_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOW;
            stab_cnt_q  <= 8'd0;
            data_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_type_q  <= 1'b0;
            evt_ovf_q   <= 1'b0;
            edge_cnt_q  <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            stab_cnt_q  <= stab_cnt_d;
            data_q      <= data_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            evt_valid_q <= evt_valid_d;
            evt_type_q  <= evt_type_d;
            evt_ovf_q   <= evt_ovf_d;
            edge_cnt_q  <= edge_cnt_d;
        end
    end

    assign o_data      = data_q;
    assign o_rise      = rise_q;
    assign o_fall      = fall_q;
    assign o_evt_valid = evt_valid_q;
    assign o_evt_type  = evt_type_q;
    assign o_evt_ovf   = evt_ovf_q;
    assign o_edge_cnt  = edge_cnt_q;

endmodule

// File: tb/tb_cdc_level_filter.sv
// Directed bench for cdc_level_filter: three instances (default, 2-bit counter, single-sample filter)
// share one stimulus; each scenario checks only the instance it targets.
module tb_cdc_level_filter;

    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;
    logic i_data = 1'b0;
    logic i_evt_ready = 1'b0;
    logic i_cnt_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic       a_data, a_rise, a_fall, a_valid, a_type, a_ovf;
    logic [7:0] a_cnt;
    logic       b_data, b_rise, b_fall, b_valid, b_type, b_ovf;
    logic [1:0] b_cnt;
    logic       c_data, c_rise, c_fall, c_valid, c_type, c_ovf;
    logic [7:0] c_cnt;

    always #5 clk_2 = ~clk_2;

    cdc_level_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(8)) u_a (
        .clk_2(clk_2), .rst_n(rst_n), .i_data(i_data), .i_evt_ready(i_evt_ready),
        .i_cnt_clr(i_cnt_clr), .o_data(a_data), .o_rise(a_rise), .o_fall(a_fall),
        .o_evt_valid(a_valid), .o_evt_type(a_type), .o_evt_ovf(a_ovf), .o_edge_cnt(a_cnt)
    );

    cdc_level_filter #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) u_b (
        .clk_2(clk_2), .rst_n(rst_n), .i_data(i_data), .i_evt_ready(i_evt_ready),
        .i_cnt_clr(i_cnt_clr), .o_data(b_data), .o_rise(b_rise), .o_fall(b_fall),
        .o_evt_valid(b_valid), .o_evt_type(b_type), .o_evt_ovf(b_ovf), .o_edge_cnt(b_cnt)
    );

    cdc_level_filter #(.STABLE_CYCLES(1), .CNT_WIDTH(8)) u_c (
        .clk_2(clk_2), .rst_n(rst_n), .i_data(i_data), .i_evt_ready(i_evt_ready),
        .i_cnt_clr(i_cnt_clr), .o_data(c_data), .o_rise(c_rise), .o_fall(c_fall),
        .o_evt_valid(c_valid), .o_evt_type(c_type), .o_evt_ovf(c_ovf), .o_edge_cnt(c_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic hold(input logic val, input int n);
        i_data = val;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Reset all instances with the given input level present during and after release.
    task automatic do_reset(input logic val);
        @(posedge clk_2);
        #1;
        rst_n = 1'b0;
        i_data = val;
        i_evt_ready = 1'b0;
        i_cnt_clr = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- Instance A: STABLE_CYCLES=4, CNT_WIDTH=8 ----------------
        do_reset(1'b0);
        check_eq("rst_data", a_data, 0);
        check_eq("rst_valid", a_valid, 0);
        check_eq("rst_cnt", a_cnt, 0);

        // Three-sample glitch must be rejected.
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 1);
            check_eq("glitch_data", a_data, 0);
            check_eq("glitch_rise", a_rise, 0);
        end
        for (int k = 0; k < 4; k++) begin
            hold(1'b0, 1);
            check_eq("glitch_data_lo", a_data, 0);
            check_eq("glitch_rise_lo", a_rise, 0);
        end
        check_eq("glitch_cnt", a_cnt, 0);
        check_eq("glitch_valid", a_valid, 0);

        // Held high from reset release: rise on the 4th edge.
        do_reset(1'b1);
        hold(1'b1, 3);
        check_eq("rise_early_data", a_data, 0);
        check_eq("rise_early_strobe", a_rise, 0);
        hold(1'b1, 1);
        check_eq("rise_data", a_data, 1);
        check_eq("rise_strobe", a_rise, 1);
        check_eq("rise_valid", a_valid, 1);
        check_eq("rise_type", a_type, 1);
        check_eq("rise_cnt", a_cnt, 1);
        hold(1'b1, 1);
        check_eq("rise_strobe_1cyc", a_rise, 0);

        // Fall while the rise event is still pending: dropped, overflow set.
        hold(1'b0, 4);
        check_eq("fall_data", a_data, 0);
        check_eq("fall_strobe", a_fall, 1);
        check_eq("drop_valid", a_valid, 1);
        check_eq("drop_type", a_type, 1);
        check_eq("drop_ovf", a_ovf, 1);
        check_eq("drop_cnt", a_cnt, 2);
        i_evt_ready = 1'b1;
        tick();
        i_evt_ready = 1'b0;
        check_eq("ack_valid", a_valid, 0);
        check_eq("ack_ovf_sticky", a_ovf, 1);
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        check_eq("clr_cnt", a_cnt, 0);
        check_eq("clr_ovf", a_ovf, 0);
        check_eq("clr_data_kept", a_data, 0);

        // Reset mid-check with an event pending.
        hold(1'b1, 4);
        hold(1'b0, 4);
        check_eq("pre_rst_ovf", a_ovf, 1);
        hold(1'b1, 2);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_data", a_data, 0);
        check_eq("async_rst_valid", a_valid, 0);
        check_eq("async_rst_ovf", a_ovf, 0);
        check_eq("async_rst_cnt", a_cnt, 0);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hold(1'b1, 1);
            check_eq("post_rst_rise_early", a_rise, 0);
        end
        hold(1'b1, 1);
        check_eq("post_rst_rise", a_rise, 1);
        check_eq("post_rst_cnt", a_cnt, 1);

        // ---------------- Instance B: CNT_WIDTH=2 saturation ----------------
        do_reset(1'b0);
        for (int e = 1; e <= 5; e++) begin
            hold(e % 2 == 1, 4);
        end
        check_eq("sat_cnt", b_cnt, 3);
        check_eq("sat_ovf", b_ovf, 1);
        check_eq("sat_data", b_data, 1);
        // 6th edge (fall) with clear and ready: count restarts at 1, no overflow.
        i_data = 1'b0;
        hold(1'b0, 3);
        i_cnt_clr = 1'b1;
        i_evt_ready = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        i_evt_ready = 1'b0;
        check_eq("clr_edge_cnt", b_cnt, 1);
        check_eq("clr_edge_ovf", b_ovf, 0);
        check_eq("clr_edge_type", b_type, 0);
        // 7th edge: clear coincides with a drop, overflow wins.
        hold(1'b1, 3);
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr = 1'b0;
        check_eq("clr_drop_ovf", b_ovf, 1);
        check_eq("clr_drop_cnt", b_cnt, 1);
        check_eq("clr_drop_type", b_type, 0);

        // ---------------- Instance C: STABLE_CYCLES=1 ----------------
        do_reset(1'b0);
        i_evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic v;
            v = (k % 2 == 0);
            hold(v, 1);
            check_eq("sc1_data", c_data, v);
            check_eq("sc1_rise", c_rise, v);
            check_eq("sc1_fall", c_fall, !v);
            check_eq("sc1_type", c_type, v);
            check_eq("sc1_ovf", c_ovf, 0);
            check_eq("sc1_cnt", c_cnt, k + 1);
        end
        i_evt_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
